// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/tag input side, decoded
// immediate output side, flush and occupancy.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [LVL_W-1:0] level;

  modport master (
    output flush, in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal, level
  );

  modport slave (
    input  flush, in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal, level
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode written into a small
// valid/ready FIFO together with a sideband tag; flush drops all entries.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t               d;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    logic [5:0]         shamt;
    i12   = inst[31:20];
    s12   = {inst[31:25], inst[11:7]};
    b13   = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u32   = {inst[31:12], 12'b0};
    j21   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // RV32 shifts only have a 5-bit shamt; bit 25 belongs to funct7 there.
    shamt = {(XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
    d.imm     = '0;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b1100111: begin
        d.imm = XLEN'(i12);
        d.fmt = FMT_I;
      end
      7'b0010011: begin
        d.fmt = FMT_I;
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) d.imm = XLEN'(shamt);
        else                                                d.imm = XLEN'(i12);
      end
      7'b0100011: begin
        d.imm = XLEN'(s12);
        d.fmt = FMT_S;
      end
      7'b1100011: begin
        d.imm = XLEN'(b13);
        d.fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        d.imm = XLEN'(u32);
        d.fmt = FMT_U;
      end
      7'b1101111: begin
        d.imm = XLEN'(j21);
        d.fmt = FMT_J;
      end
      7'b0110011: begin
        d.fmt = FMT_R;
      end
      default: begin
        d.fmt     = FMT_ILL;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  // ---- stage p0: decode and handshake on the incoming instruction ----
  dec_t             dec_p0;
  logic             vld_p0;
  logic             pop;
  logic             in_ready;
  logic             out_valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             primed;

  assign dec_p0    = decode(bus.in_inst);
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign vld_p0    = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      primed <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (vld_p0) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        primed <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({vld_p0, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // ---- stage p1: FIFO storage, head entry drives the outputs ----
  logic signed [XLEN-1:0] imm_p1 [DEPTH];
  logic [2:0]             fmt_p1 [DEPTH];
  logic                   ill_p1 [DEPTH];
  logic [TAG_W-1:0]       tag_p1 [DEPTH];

  always_ff @(posedge clk) begin
    if (vld_p0 && !bus.flush) begin
      imm_p1[wr_ptr] <= dec_p0.imm;
      fmt_p1[wr_ptr] <= dec_p0.fmt;
      ill_p1[wr_ptr] <= dec_p0.illegal;
      tag_p1[wr_ptr] <= bus.in_tag;
    end
  end

  // Storage is not reset, so the head reads as zero until something was written.
  assign bus.out_imm     = primed ? imm_p1[rd_ptr] : '0;
  assign bus.out_fmt     = primed ? fmt_p1[rd_ptr] : '0;
  assign bus.out_illegal = primed ? ill_p1[rd_ptr] : 1'b0;
  assign bus.out_tag     = primed ? tag_p1[rd_ptr] : '0;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.level       = level;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed instructions with hand-computed
// immediates on an XLEN=32 and an XLEN=64 instance.
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t q32[$];
  exp_t q64[$];

  imm_gen_pipe_if #(.XLEN(32), .DEPTH(2), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .DEPTH(2), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog elapsed tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready && !b32.flush) begin
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL mon32 unexpected entry tag=%h", b32.out_tag);
      end else begin
        exp_t e;
        e = q32.pop_front();
        if (b32.out_imm !== e.imm[31:0] || b32.out_fmt !== e.fmt ||
            b32.out_illegal !== e.ill || b32.out_tag !== e.tag) begin
          fails++;
          $display("FAIL mon32 actual imm=%h fmt=%0d ill=%b tag=%h expected imm=%h fmt=%0d ill=%b tag=%h",
                   b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag,
                   e.imm[31:0], e.fmt, e.ill, e.tag);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b64.out_valid && b64.out_ready && !b64.flush) begin
      tests++;
      if (q64.size() == 0) begin
        fails++;
        $display("FAIL mon64 unexpected entry tag=%h", b64.out_tag);
      end else begin
        exp_t e;
        e = q64.pop_front();
        if (b64.out_imm !== e.imm || b64.out_fmt !== e.fmt ||
            b64.out_illegal !== e.ill || b64.out_tag !== e.tag) begin
          fails++;
          $display("FAIL mon64 actual imm=%h fmt=%0d ill=%b tag=%h expected imm=%h fmt=%0d ill=%b tag=%h",
                   b64.out_imm, b64.out_fmt, b64.out_illegal, b64.out_tag,
                   e.imm, e.fmt, e.ill, e.tag);
        end
      end
    end
  end

  // Presents one instruction, records its expectation once accepted, and
  // returns just after the accepting edge with in_valid still asserted.
  task automatic send(input bit wide, input logic [31:0] inst, input logic [31:0] tag,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    exp_t e;
    int   n;
    bit   rdy;
    e = '{imm: imm, fmt: fmt, ill: ill, tag: tag};
    if (wide) begin
      b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_tag = tag;
    end else begin
      b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_tag = tag;
    end
    n = 0;
    @(negedge clk);
    rdy = wide ? b64.in_ready : b32.in_ready;
    while (!rdy && n < 40) begin
      n++;
      @(negedge clk);
      rdy = wide ? b64.in_ready : b32.in_ready;
    end
    if (rdy) begin
      if (wide) q64.push_back(e);
      else      q32.push_back(e);
    end else begin
      tests++;
      fails++;
      $display("FAIL send timeout inst=%h in_ready=0 expected 1", inst);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
  endtask

  logic [31:0] sw_inst [0:8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h0000007F,
                                 32'h12345037, 32'h0010006F, 32'h00000033, 32'h41F0D093,
                                 32'h03F09093};
  logic [31:0] sw_imm  [0:8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000,
                                 32'h12345000, 32'h00000800, 32'h00000000, 32'h0000001F,
                                 32'h0000001F};
  logic [2:0]  sw_fmt  [0:8] = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd0, 3'd1, 3'd1};

  logic [11:0] wr_i12  [0:11] = '{12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h123, 12'hABC,
                                  12'h000, 12'h555, 12'hAAA, 12'hFFE, 12'h400, 12'hC00};
  logic [31:0] wr_imm  [0:11] = '{32'h00000001, 32'h000007FF, 32'hFFFFF800, 32'hFFFFFFFF,
                                  32'h00000123, 32'hFFFFFABC, 32'h00000000, 32'h00000555,
                                  32'hFFFFFAAA, 32'hFFFFFFFE, 32'h00000400, 32'hFFFFFC00};

  logic [31:0] w_inst  [0:7] = '{32'hFFF00093, 32'h43F0D093, 32'h03F09093, 32'h80000037,
                                 32'hFE112E23, 32'h0010006F, 32'hFE000EE3, 32'h0000007F};
  logic [63:0] w_imm   [0:7] = '{64'hFFFFFFFFFFFFFFFF, 64'h000000000000003F, 64'h000000000000003F,
                                 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000800,
                                 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000000};
  logic [2:0]  w_fmt   [0:7] = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd7};

  initial begin
    clk = 1'b0; rst_n = 1'b0; tests = 0; fails = 0;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_tag = '0; b32.out_ready = 1'b0;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_tag = '0; b64.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst_in_ready", 64'(b32.in_ready), 64'd1);
    check("rst_level", 64'(b32.level), 64'd0);
    check("rst_out_imm", 64'(b32.out_imm), 64'd0);
    check("rst_out_fmt_tag_ill", {29'd0, b32.out_fmt, b32.out_tag, 31'd0, b32.out_illegal}, 64'd0);
    rst_n = 1'b1;

    // decode sweep, streaming at level 1
    b32.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(1'b0, sw_inst[i], 32'h1000 + 32'(i * 4), {32'd0, sw_imm[i]}, sw_fmt[i], sw_fmt[i] == 3'd7);
      check("sweep_level", 64'(b32.level), 64'd1);
    end
    idle();
    repeat (3) @(posedge clk); #1;
    check("sweep_drained", 64'(b32.out_valid), 64'd0);

    // simultaneous push/pop across several pointer wraps
    for (int i = 0; i < 12; i++) begin
      send(1'b0, {wr_i12[i], 5'd0, 3'b000, 5'd2, 7'b0010011}, 32'h2000 + 32'(i),
           {32'd0, wr_imm[i]}, 3'd1, 1'b0);
      check("wrap_level", 64'(b32.level), 64'd1);
    end
    idle();
    repeat (3) @(posedge clk); #1;

    // back-pressure
    b32.out_ready = 1'b0;
    send(1'b0, 32'h00500093, 32'hA0A0A0A0, 64'h5, 3'd1, 1'b0);
    send(1'b0, 32'hFFFFF037, 32'hB0B0B0B0, 64'hFFFFF000, 3'd4, 1'b0);
    check("bp_level_full", 64'(b32.level), 64'd2);
    check("bp_in_ready_full", 64'(b32.in_ready), 64'd0);
    b32.in_inst = 32'h00000033; b32.in_tag = 32'hC0C0C0C0;
    @(negedge clk);
    check("bp_third_blocked", 64'(b32.in_ready), 64'd0);
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", 64'(b32.in_ready), 64'd0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", 64'(b32.in_ready), 64'd1);
    check("bp_level_after_pop", 64'(b32.level), 64'd1);
    send(1'b0, 32'h00000033, 32'hC0C0C0C0, 64'h0, 3'd0, 1'b0);
    idle();
    repeat (4) @(posedge clk); #1;
    check("bp_drained", 64'(b32.level), 64'd0);

    // flush at level 2 with in_valid and out_ready active
    b32.out_ready = 1'b0;
    send(1'b0, 32'h00100093, 32'hD1, 64'h1, 3'd1, 1'b0);
    send(1'b0, 32'h00200093, 32'hD2, 64'h2, 3'd1, 1'b0);
    b32.in_inst = 32'h00700093; b32.in_tag = 32'hD3;
    b32.out_ready = 1'b1; b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0; idle();
    q32.delete();
    check("flush2_level", 64'(b32.level), 64'd0);
    check("flush2_out_valid", 64'(b32.out_valid), 64'd0);
    check("flush2_in_ready", 64'(b32.in_ready), 64'd1);

    // flush at level 1 while a push is being offered
    b32.out_ready = 1'b0;
    send(1'b0, 32'h00300093, 32'hE1, 64'h3, 3'd1, 1'b0);
    b32.in_inst = 32'h00400093; b32.in_tag = 32'hE2; b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0; idle();
    q32.delete();
    check("flush1_push_dropped", 64'(b32.level), 64'd0);
    b32.out_ready = 1'b1;
    send(1'b0, 32'h00900093, 32'hE3, 64'h9, 3'd1, 1'b0);
    idle();
    repeat (3) @(posedge clk); #1;

    // asynchronous reset mid-stream
    b32.out_ready = 1'b0;
    send(1'b0, 32'h00A00093, 32'hF1, 64'hA, 3'd1, 1'b0);
    send(1'b0, 32'h00B00093, 32'hF2, 64'hB, 3'd1, 1'b0);
    idle();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(b32.out_valid), 64'd0);
    check("arst_in_ready", 64'(b32.in_ready), 64'd1);
    check("arst_level", 64'(b32.level), 64'd0);
    check("arst_out_imm", 64'(b32.out_imm), 64'd0);
    q32.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    b32.out_ready = 1'b1;
    send(1'b0, 32'h00C00093, 32'hF3, 64'hC, 3'd1, 1'b0);
    idle();

    // XLEN=64 decode
    b64.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, w_inst[i], 32'h3000 + 32'(i), w_imm[i], w_fmt[i], w_fmt[i] == 3'd7);
    end
    idle();
    repeat (5) @(posedge clk); #1;
    check("q32_empty", 64'(q32.size()), 64'd0);
    check("q64_empty", 64'(q64.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
